slow_clk_monitor: RTL and testbench
===================================

SLOW_CLK_MONITOR -- requirements
Module: slow_clk_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per channel, legal range 2..4.
REQ-002 SHALL have parameter TIMEOUT, default 30_000_000: clk_100MHz cycles without any edge before a channel is flagged lost.
REQ-003 SHALL have parameter PERIOD_W, default 28: width of the period counter and period outputs.
REQ-004 SHALL have port clk_100MHz  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port slow_clk_in  input  2  slow clocks, asynchronous to clk_100MHz; bit 0 = channel 0 (write side), bit 1 = channel 1 (read side).
REQ-007 SHALL have port rise_tick  output  2  one-cycle pulse per synchronized rising edge, per channel.
REQ-008 SHALL have port fall_tick  output  2  one-cycle pulse per synchronized falling edge, per channel.
REQ-009 SHALL have port period0  output  PERIOD_W  last measured rise-to-rise period of channel 0, in clk_100MHz cycles.
REQ-010 SHALL have port period1  output  PERIOD_W  same for channel 1.
REQ-011 SHALL have port period_valid  output  2  one-cycle pulse per channel when periodN updates.
REQ-012 SHALL have port lost  output  2  level, per channel: no edge seen for TIMEOUT cycles.

Function
REQ-013 Each channel SHALL pass through a SYNC_STAGES-deep flop chain followed by one previous-value register; channels are fully independent.
REQ-014 Rise/fall SHALL be detected from sync output vs previous register; an input transition sampled at edge N SHALL produce its tick at edge N+SYNC_STAGES.
REQ-015 Each tick SHALL be exactly one cycle wide; rise and fall ticks of one channel SHALL never coincide.
REQ-016 Per-channel FSM states: IDLE (no reference rise), MEASURE (reference rise held), LOST.
REQ-017 IDLE: rise_tick -> MEASURE, period counter loaded to 1, no period_valid.
REQ-018 MEASURE: each cycle period counter +1, saturating at 2^PERIOD_W-1; on rise_tick periodN <= counter value, period_valid pulses in the same cycle as rise_tick, counter reloads to 1.
REQ-019 A saturated period SHALL be reported as 2^PERIOD_W-1, never wrapped.
REQ-020 Idle counter per channel SHALL reset to 0 on any rise or fall tick and otherwise increment, saturating at TIMEOUT.
REQ-021 Any state: idle counter reaching TIMEOUT -> LOST; lost bit asserts in the cycle after the counter equals TIMEOUT.
REQ-022 LOST: rise_tick -> MEASURE (counter=1, no period_valid); fall_tick -> IDLE; lost bit deasserts in the same cycle as that tick.
REQ-023 periodN SHALL hold its last value through IDLE and LOST.
REQ-024 Ticks SHALL be emitted in every state, including LOST.

Reset
REQ-025 Reset SHALL asynchronously clear sync chains, previous registers, counters, periodN, rise_tick, fall_tick, period_valid, lost to 0 and put both FSMs in IDLE.
REQ-026 Ticks SHALL be suppressed for the first SYNC_STAGES+1 cycles after reset deassertion, with previous registers still loading, so a slow clock held high at release yields no rise_tick.
REQ-027 Reset asserted mid-measurement SHALL discard the partial count; first rise after release returns to REQ-017 behaviour.

Verification
REQ-028 SYNC_STAGES=2: slow_clk_in[0] 0->1 just before edge 10 -> rise_tick[0] high only at edge 12, fall_tick stays 0.
REQ-029 Channel 0 toggles every 50 cycles (period 100): first rise no period_valid; each later rise -> period0=100, period_valid[0] one cycle.
REQ-030 TIMEOUT=200, channel 1 stops toggling -> lost[1] rises 201 cycles after last tick; next rise clears lost[1], no period_valid, following rise reports true period.
REQ-031 PERIOD_W=8, channel 0 rise spacing 300 -> period0=255.
REQ-032 slow_clk_in=2'b11 at reset release -> no ticks; first rise_tick only after a real 0->1 transition.
REQ-033 Channels 0 (period 100) and 1 (period 40) run concurrently with coincident edges -> both ticks and period_valid bits assert in the same cycle, values 100 and 40.

Source files
------------

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: two-channel slow clock monitor in the clk_100MHz domain.
// Synchronizes each slow clock, emits edge ticks, measures the rise-to-rise
// period and flags a channel as lost after TIMEOUT cycles without any edge.
// Ports: clk_100MHz, reset (async, active-high), slow_clk_in[1:0] (async in),
//        rise_tick/fall_tick[1:0] (1-cycle pulses), period0/period1 (last
//        period), period_valid[1:0] (update pulse), lost[1:0] (timeout level).
module slow_clk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 30_000_000,
    parameter int PERIOD_W    = 28
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    input  logic [1:0]          slow_clk_in,
    output logic [1:0]          rise_tick,
    output logic [1:0]          fall_tick,
    output logic [PERIOD_W-1:0] period0,
    output logic [PERIOD_W-1:0] period1,
    output logic [1:0]          period_valid,
    output logic [1:0]          lost
);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
    localparam logic [PERIOD_W-1:0] PER_MAX = '1;
    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_LOST
    } state_t;

    logic [2:0]          r_warm;
    logic                w_armed;
    logic [PERIOD_W-1:0] w_period [2];

    // Edge detection stays gated until the sync chain and previous
    // register hold real samples, so a clock high at release is no edge.
    assign w_armed = (r_warm == WARM_DONE);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_warm <= '0;
        end else if (!w_armed) begin
            r_warm <= r_warm + 3'd1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_prev;
        logic                   r_rise;
        logic                   r_fall;
        logic                   r_pv;
        logic                   r_lost;
        logic [PERIOD_W-1:0]    r_cnt;
        logic [PERIOD_W-1:0]    r_per;
        logic [IDLE_W-1:0]      r_idle;
        state_t                 r_state;
        logic                   w_sync;
        logic                   w_rise;
        logic                   w_fall;
        logic                   w_tmo;

        assign w_sync = r_sync[SYNC_STAGES-1];
        assign w_rise = w_armed & w_sync & ~r_prev;
        assign w_fall = w_armed & ~w_sync & r_prev;
        assign w_tmo  = (r_idle == IDLE_MAX);

        always_ff @(posedge clk_100MHz or posedge reset) begin
            if (reset) begin
                r_sync  <= '0;
                r_prev  <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                r_pv    <= 1'b0;
                r_lost  <= 1'b0;
                r_cnt   <= '0;
                r_per   <= '0;
                r_idle  <= '0;
                r_state <= S_IDLE;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], slow_clk_in[g]};
                r_prev <= w_sync;
                r_rise <= w_rise;
                r_fall <= w_fall;
                r_pv   <= 1'b0;

                if (w_rise || w_fall) begin
                    r_idle <= '0;
                end else if (!w_tmo) begin
                    r_idle <= r_idle + IDLE_ONE;
                end

                // A tick in the same cycle as the timeout wins:
                // it proves the clock is still alive.
                case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            r_state <= S_MEASURE;
                            r_cnt   <= CNT_ONE;
                        end else if (w_tmo && !w_fall) begin
                            r_state <= S_LOST;
                            r_lost  <= 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        if (w_rise) begin
                            r_per <= r_cnt;
                            r_pv  <= 1'b1;
                            r_cnt <= CNT_ONE;
                        end else if (w_tmo && !w_fall) begin
                            r_state <= S_LOST;
                            r_lost  <= 1'b1;
                        end else if (r_cnt != PER_MAX) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    S_LOST: begin
                        if (w_rise) begin
                            r_state <= S_MEASURE;
                            r_cnt   <= CNT_ONE;
                            r_lost  <= 1'b0;
                        end else if (w_fall) begin
                            r_state <= S_IDLE;
                            r_lost  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end

        assign rise_tick[g]    = r_rise;
        assign fall_tick[g]    = r_fall;
        assign period_valid[g] = r_pv;
        assign lost[g]         = r_lost;
        assign w_period[g]     = r_per;
    end

    assign period0 = w_period[0];
    assign period1 = w_period[1];

endmodule

// File: tb/tb_slow_clk_monitor.sv
// tb_slow_clk_monitor: scoreboard bench for slow_clk_monitor.
// Expected ticks/periods are queued at stimulus time and popped on output.
module tb_slow_clk_monitor;
    localparam int TO   = 200;
    localparam int PW   = 8;
    localparam int PMAX = 255;

    logic          clk_100MHz = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    slow_clk_in = 2'b00;
    logic [1:0]    rise_tick;
    logic [1:0]    fall_tick;
    logic [PW-1:0] period0;
    logic [PW-1:0] period1;
    logic [1:0]    period_valid;
    logic [1:0]    lost;

    always #5 clk_100MHz = ~clk_100MHz;

    slow_clk_monitor #(
        .SYNC_STAGES(2),
        .TIMEOUT(TO),
        .PERIOD_W(PW)
    ) u_dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .slow_clk_in(slow_clk_in),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .period0(period0),
        .period1(period1),
        .period_valid(period_valid),
        .lost(lost)
    );

    typedef struct {
        int cyc;
        bit rise;
        bit fall;
        bit pv;
        int per;
    } evt_t;

    evt_t q0[$];
    evt_t q1[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit [1:0] lvl = 2'b00;
    bit [1:0] has_ref = 2'b00;
    int ref_t [2];
    int old_t [2];
    int new_t [2];

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int ch);
        return (ch == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpop(input int ch, output evt_t e);
        if (ch == 0) e = q0.pop_front();
        else e = q1.pop_front();
    endtask

    task automatic qpeek(input int ch, output evt_t e);
        if (ch == 0) e = q0[0];
        else e = q1[0];
    endtask

    // Drive one channel at a negedge and queue what the DUT must show.
    task automatic set_in(input int ch, input bit v);
        evt_t e;
        int t;
        if (lvl[ch] == v) return;
        lvl[ch] = v;
        slow_clk_in[ch] = v;
        t = cyc + 3;
        e.cyc = t;
        e.rise = v;
        e.fall = !v;
        e.pv = 1'b0;
        e.per = 0;
        if ((t - 1 - new_t[ch]) >= TO + 1) begin
            has_ref[ch] = v;
            ref_t[ch] = t;
        end else if (v) begin
            if (has_ref[ch]) begin
                e.pv = 1'b1;
                e.per = (t - ref_t[ch] > PMAX) ? PMAX : t - ref_t[ch];
            end
            has_ref[ch] = 1'b1;
            ref_t[ch] = t;
        end
        old_t[ch] = new_t[ch];
        new_t[ch] = t;
        if (ch == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon_ch(input int ch);
        evt_t e;
        int sz;
        int eff;
        bit r;
        bit f;
        bit p;
        int per;
        r = rise_tick[ch];
        f = fall_tick[ch];
        p = period_valid[ch];
        per = (ch == 0) ? int'(period0) : int'(period1);
        sz = qsize(ch);
        if (sz > 0) begin
            qpeek(ch, e);
            if (e.cyc < cyc) begin
                qpop(ch, e);
                check($sformatf("ch%0d_missed_evt", ch), cyc, e.cyc);
                sz--;
            end
        end
        check($sformatf("ch%0d_rise_and_fall", ch), r & f, 0);
        if (r | f | p) begin
            check($sformatf("ch%0d_evt_expected", ch), sz > 0, 1);
            if (sz > 0) begin
                qpop(ch, e);
                check($sformatf("ch%0d_evt_cyc", ch), cyc, e.cyc);
                check($sformatf("ch%0d_rise", ch), r, e.rise);
                check($sformatf("ch%0d_fall", ch), f, e.fall);
                check($sformatf("ch%0d_pvalid", ch), p, e.pv);
                if (e.pv) check($sformatf("ch%0d_period", ch), per, e.per);
            end
        end
        eff = (cyc >= new_t[ch]) ? new_t[ch] : old_t[ch];
        check($sformatf("ch%0d_lost", ch), lost[ch],
              int'((cyc - eff) >= TO + 1));
    endtask

    always @(posedge clk_100MHz) begin
        #1;
        if (mon_en && !reset) begin
            for (int ch = 0; ch < 2; ch++) mon_ch(ch);
        end
    end

    task automatic do_reset(input bit [1:0] v);
        @(negedge clk_100MHz);
        check("sb_drain0", q0.size(), 0);
        check("sb_drain1", q1.size(), 0);
        q0.delete();
        q1.delete();
        reset = 1'b1;
        slow_clk_in = v;
        lvl = v;
        repeat (3) @(negedge clk_100MHz);
        check("rst_rise", rise_tick, 0);
        check("rst_fall", fall_tick, 0);
        check("rst_pvalid", period_valid, 0);
        check("rst_lost", lost, 0);
        check("rst_period0", period0, 0);
        check("rst_period1", period1, 0);
        reset = 1'b0;
        has_ref = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            old_t[ch] = cyc;
            new_t[ch] = cyc;
            ref_t[ch] = cyc;
        end
        mon_en = 1'b1;
    endtask

    task automatic run(input int n, input int h0, input int h1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100MHz);
            if (h0 > 0 && i % h0 == 0) set_in(0, !lvl[0]);
            if (h1 > 0 && i % h1 == 0) set_in(1, !lvl[1]);
        end
    endtask

    initial begin
        // single rise: tick exactly SYNC_STAGES edges after sampling
        do_reset(2'b00);
        run(5, 0, 0);
        run(1, 1, 0);
        run(20, 0, 0);

        // ch0 period 100; ch1 idle goes lost
        do_reset(2'b00);
        run(450, 50, 0);
        run(10, 0, 0);

        // ch1 stops, goes lost, rise recovers, then period 40
        do_reset(2'b00);
        run(80, 0, 20);
        run(300, 0, 0);
        run(41, 0, 20);
        run(10, 0, 0);

        // reset mid-measurement discards the partial count
        do_reset(2'b00);
        run(31, 50, 0);
        do_reset(2'b00);
        run(201, 50, 0);
        run(10, 0, 0);

        // rise spacing 300 saturates an 8-bit period
        do_reset(2'b00);
        run(700, 150, 0);
        run(10, 0, 0);

        // concurrent channels with coincident edges
        do_reset(2'b00);
        run(401, 50, 20);
        run(10, 0, 0);

        // clocks high at release give no tick
        do_reset(2'b11);
        run(20, 0, 0);
        run(31, 15, 0);
        run(10, 0, 0);

        @(negedge clk_100MHz);
        check("final_drain0", q0.size(), 0);
        check("final_drain1", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
